// File: rtl/imm_gen_stage.sv
// Registered RV32I/RV64I immediate generator with valid/ready output and optional skid slot.
// Optional Zicsr zimm decode (imm_src=101) enabled by defining IMM_GEN_ZIMM_EN.
module imm_gen_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SKID_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_ext,
    output logic            imm_fmt_err
);

    localparam int unsigned IW = 32;

    logic [IW-1:0]   imm32;
    logic [XLEN-1:0] dec_imm;
    logic            dec_err;

    logic            skid_valid;
    logic [XLEN-1:0] skid_imm;
    logic            skid_err;

    logic            out_valid_d;
    logic [XLEN-1:0] imm_ext_d;
    logic            imm_fmt_err_d;
    logic            skid_valid_d;
    logic [XLEN-1:0] skid_imm_d;
    logic            skid_err_d;

    logic            in_fire;
    logic            out_free;

    // Format decode to a 32-bit value; every format except zimm is sign-extended from bit 31
    always_comb begin
        imm32   = '0;
        dec_err = 1'b0;
        case (imm_src)
            3'b000:  imm32 = {{20{instr[31]}}, instr[31:20]};
            3'b001:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            3'b010:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            3'b011:  imm32 = {instr[31:12], 12'b0};
            3'b100:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef IMM_GEN_ZIMM_EN
            3'b101:  imm32 = {27'b0, instr[19:15]};
`endif
            default: begin
                imm32   = '0;
                dec_err = 1'b1;
            end
        endcase
    end

    assign dec_imm = XLEN'($signed(imm32));

    generate
        if (SKID_EN != 0) begin : g_skid_ready
            assign in_ready = ~rst & ~skid_valid;
        end else begin : g_noskid_ready
            assign in_ready = ~rst & (out_ready | ~out_valid);
        end
    endgenerate

    assign in_fire  = in_valid & in_ready;
    assign out_free = ~out_valid | out_ready;

    // Next state: flush wins, then drain skid into output, then load new beat
    always_comb begin
        out_valid_d   = out_valid;
        imm_ext_d     = imm_ext;
        imm_fmt_err_d = imm_fmt_err;
        skid_valid_d  = skid_valid;
        skid_imm_d    = skid_imm;
        skid_err_d    = skid_err;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid_d   = 1'b1;
                imm_ext_d     = skid_imm;
                imm_fmt_err_d = skid_err;
                skid_valid_d  = in_fire;
                if (in_fire) begin
                    skid_imm_d = dec_imm;
                    skid_err_d = dec_err;
                end
            end else if (in_fire) begin
                out_valid_d   = 1'b1;
                imm_ext_d     = dec_imm;
                imm_fmt_err_d = dec_err;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_err_d   = dec_err;
        end
        if (SKID_EN == 0) begin
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            imm_ext     <= '0;
            imm_fmt_err <= 1'b0;
            skid_valid  <= 1'b0;
            skid_imm    <= '0;
            skid_err    <= 1'b0;
        end else begin
            out_valid   <= out_valid_d;
            imm_ext     <= imm_ext_d;
            imm_fmt_err <= imm_fmt_err_d;
            skid_valid  <= skid_valid_d;
            skid_imm    <= skid_imm_d;
            skid_err    <= skid_err_d;
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Scoreboard bench for imm_gen_stage: directed test-plan beats, randomized traffic, flush and async reset.
module tb_imm_gen_stage;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     instr = '0;
    logic [2:0]      imm_src = '0;
    logic            flush = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] imm_ext;
    logic            imm_fmt_err;

    logic            in_valid_b = 1'b0;
    logic            in_ready_b;
    logic [31:0]     instr_b = '0;
    logic [2:0]      imm_src_b = '0;
    logic            out_valid_b;
    logic            out_ready_b = 1'b0;
    logic [63:0]     imm_ext_b;
    logic            imm_fmt_err_b;

    int tests = 0;
    int fails = 0;
    logic [XLEN:0] sb[$];

    imm_gen_stage #(.XLEN(XLEN), .SKID_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .imm_src(imm_src), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .imm_ext(imm_ext), .imm_fmt_err(imm_fmt_err)
    );

    imm_gen_stage #(.XLEN(64), .SKID_EN(0)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .instr(instr_b), .imm_src(imm_src_b), .flush(1'b0), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .imm_ext(imm_ext_b), .imm_fmt_err(imm_fmt_err_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: assemble the immediate field as an integer, then apply two's-complement sign
    function automatic logic [XLEN:0] model(input logic [31:0] i, input logic [2:0] src);
        longint v;
        longint w;
        logic   e;
        v = 0;
        e = 1'b0;
        w = longint'(i);
        case (src)
            3'd0: begin v = w >> 20; if (v >= 2048) v -= 4096; end
            3'd1: begin
                v = (((w >> 25) & 127) << 5) | ((w >> 7) & 31);
                if (v >= 2048) v -= 4096;
            end
            3'd2: begin
                v = (((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11)
                  | (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1);
                if (v >= 4096) v -= 8192;
            end
            3'd3: begin
                v = w & 64'hFFFF_F000;
                if (v >= 64'h8000_0000) v -= 64'h1_0000_0000;
            end
            3'd4: begin
                v = (((w >> 31) & 1) << 20) | (((w >> 12) & 255) << 12)
                  | (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1);
                if (v >= 64'h10_0000) v -= 64'h20_0000;
            end
`ifdef IMM_GEN_ZIMM_EN
            3'd5: v = (w >> 15) & 31;
`endif
            default: e = 1'b1;
        endcase
        if (e) v = 0;
        return {e, XLEN'(v)};
    endfunction

    // Monitor: occupancy, handshake and in-order data checks against the expectation queue
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            chk("out_valid_vs_occupancy", 64'(out_valid), 64'(sb.size() > 0));
            chk("in_ready_vs_occupancy", 64'(in_ready), 64'(sb.size() < 2));
            if (out_valid && sb.size() > 0) begin
                chk("imm_ext", 64'(imm_ext), 64'(sb[0][XLEN-1:0]));
                chk("imm_fmt_err", 64'(imm_fmt_err), 64'(sb[0][XLEN]));
                if (out_ready) void'(sb.pop_front());
            end
            if (in_valid && in_ready && !flush) sb.push_back(model(instr, imm_src));
            if (flush) sb.delete();
        end
    end

    task automatic drive(input logic iv, input logic [31:0] ins, input logic [2:0] src,
                         input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = iv;
        instr     = ins;
        imm_src   = src;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic iv, ordy, fl;
        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_imm_ext", 64'(imm_ext), 64'd0);
        chk("rst_fmt_err", 64'(imm_fmt_err), 64'd0);
        chk("rst_out_valid64", 64'(out_valid_b), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Back-to-back beats with out_ready high, one-cycle latency
        drive(1'b1, 32'hFFF0_0093, 3'd0, 1'b1, 1'b0);
        drive(1'b1, 32'hFE11_2E23, 3'd1, 1'b1, 1'b0);
        @(negedge clk);
        chk("lat_out_valid", 64'(out_valid), 64'd1);
        chk("I_addi_neg1", 64'(imm_ext), 64'hFFFF_FFFF);
        drive(1'b1, 32'h1234_50B7, 3'd3, 1'b1, 1'b0);
        @(negedge clk);
        chk("S_sw_neg4", 64'(imm_ext), 64'hFFFF_FFFC);
        drive(1'b1, 32'hFFDF_F06F, 3'd4, 1'b1, 1'b0);
        @(negedge clk);
        chk("U_lui", 64'(imm_ext), 64'h1234_5000);
        drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("J_jal_neg4", 64'(imm_ext), 64'hFFFF_FFFC);

        // Skid: two beats against a stalled output, then drain in order
        drive(1'b1, 32'h0050_0093, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 32'h1234_50B7, 3'd3, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("skid_in_ready_low", 64'(in_ready), 64'd0);
        chk("skid_hold_first", 64'(imm_ext), 64'h5);
        drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("skid_drain_first", 64'(imm_ext), 64'h5);
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk("skid_drain_second", 64'(imm_ext), 64'h1234_5000);
        chk("skid_drain_second_valid", 64'(out_valid), 64'd1);
        drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

        // Flush with two entries held and an input offered
        drive(1'b1, 32'h0010_0093, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 32'h8000_0063, 3'd2, 1'b0, 1'b0);
        drive(1'b1, 32'h0070_0093, 3'd0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("flush2_out_valid", 64'(out_valid), 64'd0);
        chk("flush2_in_ready", 64'(in_ready), 64'd1);
        // Flush with one entry held while in_ready is high: offered beat must vanish
        drive(1'b1, 32'h0020_0093, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 32'h0030_0093, 3'd0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        chk("flush1_out_valid", 64'(out_valid), 64'd0);
        repeat (3) drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);

        // Reserved and Z codes
        drive(1'b1, 32'hFFF0_0093, 3'd6, 1'b1, 1'b0);
        drive(1'b1, 32'h0002_D073, 3'd5, 1'b1, 1'b0);
        @(negedge clk);
        chk("rsv_fmt_err", 64'(imm_fmt_err), 64'd1);
        chk("rsv_imm_zero", 64'(imm_ext), 64'd0);
        drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
`ifdef IMM_GEN_ZIMM_EN
        chk("zimm_value", 64'(imm_ext), 64'h5);
        chk("zimm_fmt_err", 64'(imm_fmt_err), 64'd0);
`else
        chk("zimm_disabled_err", 64'(imm_fmt_err), 64'd1);
        chk("zimm_disabled_imm", 64'(imm_ext), 64'd0);
`endif

        // XLEN=64, no-skid instance
        @(posedge clk);
        #1;
        in_valid_b = 1'b1; instr_b = 32'h8000_00B7; imm_src_b = 3'd3; out_ready_b = 1'b1;
        @(posedge clk);
        #1 in_valid_b = 1'b0;
        @(negedge clk);
        chk("x64_out_valid", 64'(out_valid_b), 64'd1);
        chk("x64_U_neg", imm_ext_b, 64'hFFFF_FFFF_8000_0000);
        @(posedge clk);
        #1;
        in_valid_b = 1'b1; instr_b = 32'hFFF0_0093; imm_src_b = 3'd0; out_ready_b = 1'b0;
        @(posedge clk);
        #1 in_valid_b = 1'b0;
        @(negedge clk);
        chk("x64_I_neg1", imm_ext_b, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("x64_noskid_in_ready", 64'(in_ready_b), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            iv   = 1'($urandom_range(0, 1));
            fl   = ($urandom_range(0, 31) == 0);
            ordy = fl ? 1'b0 : ($urandom_range(0, 3) != 0);
            drive(iv, $urandom, 3'($urandom_range(0, 7)), ordy, fl);
        end
        drive(1'b0, 32'h0, 3'd0, 1'b1, 1'b0);
        for (int n = 0; n < 10 && sb.size() > 0; n++) @(negedge clk);
        chk("drain_empty", 64'(sb.size()), 64'd0);

        // Asynchronous reset with an entry held in both instances
        drive(1'b1, 32'h0050_0093, 3'd0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 3'd0, 1'b0, 1'b0);
        chk("pre_async_rst_valid", 64'(out_valid), 64'd1);
        chk("pre_async_rst_valid64", 64'(out_valid_b), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd0);
        chk("async_rst_out_valid64", 64'(out_valid_b), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_async_in_ready", 64'(in_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Registered, parametrised immediate generator sitting between the fetch/IF-ID boundary and the decode/execute datapath.
- Decodes all RV32I/RV64I immediate formats (I, S, B, U, J) from a raw instruction word and sign-extends each to XLEN.
- Results leave through a valid/ready output register backed by a one-entry skid buffer, so upstream stalls are absorbed without combinational ready paths.
- Flush support lets the hazard unit squash in-flight results on a branch redirect.

Parameters:
- XLEN, 32, datapath width of imm_ext; legal values 32 or 64.
- SKID_EN, 1, 1 = one-entry skid buffer present (in_ready registered); 0 = no skid (in_ready = out_ready | ~out_valid).

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  instr/imm_src valid this cycle.
- in_ready  output  1  stage can accept input this cycle.
- instr  input  32  raw instruction word.
- imm_src  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (macro-dependent), 110/111 reserved.
- flush  input  1  synchronous squash of all held entries.
- out_valid  output  1  imm_ext/imm_fmt_err valid.
- out_ready  input  1  downstream accepts the output this cycle.
- imm_ext  output  XLEN  sign-extended immediate.
- imm_fmt_err  output  1  imm_src was reserved or disabled for this entry.

Behaviour:
- Clocking and reset: single clock domain. rst is asynchronous and active-high.
- State during/after reset:
  - out_valid=0, imm_ext=0, imm_fmt_err=0, skid_valid=0.
  - in_ready=0 while rst is high; in_ready=1 in the first cycle after release.
- Transfers: an input transfer occurs on in_valid & in_ready; an output transfer occurs on out_valid & out_ready.
- Latency: 1 cycle from input transfer to out_valid when the output register is empty or draining.
- Formats (S = instr[31] replicated to fill XLEN):
  - I: {S, instr[31:20]}
  - S: {S, instr[31:25], instr[11:7]}
  - B: {S, instr[7], instr[30:25], instr[11:8], 1'b0}
  - U: {S, instr[31:12], 12'b0}. For XLEN=64, bits 63:32 = instr[31].
  - J: {S, instr[19:12], instr[20], instr[30:21], 1'b0}
  - Reserved or disabled codes: imm_ext=0, imm_fmt_err=1. The entry still flows normally; it is never dropped.
- Output register: loads on an input transfer when it is empty or performs an output transfer in the same cycle. Otherwise the decoded entry goes to the skid register.
- Skid (SKID_EN=1):
  - in_ready = ~skid_valid (registered).
  - skid_valid sets when an input is accepted while the output is held (out_valid & ~out_ready).
  - When the output drains, the skid entry moves to the output register the next edge; a new input accepted that same cycle goes into the now-free skid slot.
  - Order is strictly FIFO; there are at most 2 entries in flight.
- SKID_EN=0: in_ready = out_ready | ~out_valid (combinational); the skid register is absent.
- Flush:
  - On a clk edge with flush=1, out_valid=0 and skid_valid=0.
  - An input presented in the flush cycle is discarded.
  - flush overrides simultaneous in/out transfers.
  - in_ready=1 on the next cycle.
- Reset mid-operation: all held entries are lost immediately (asynchronous); no partial output is produced.
- Data hold: imm_ext and imm_fmt_err stay stable while out_valid & ~out_ready. Their values while out_valid=0 are don't-care but hold their last value (no toggling).

Optional Feature:
- Macro: IMM_GEN_ZIMM_EN.
- Defined: imm_src=101 selects Zicsr zimm = zero-extended instr[19:15] (upper XLEN-5 bits zero), with imm_fmt_err=0.
- Undefined: 101 is reserved and gives imm_ext=0, imm_fmt_err=1. No zimm logic is synthesised.

Test Plan:
- XLEN=32, instr=0xFFF00093, imm_src=000, out_ready=1 -> one cycle later out_valid=1, imm_ext=0xFFFFFFFF, imm_fmt_err=0.
- Back-to-back beats, all with out_ready=1 -> each output one cycle after its input:
  - 0xFE112E23 (S) -> 0xFFFFFFFC
  - 0x123450B7 (U) -> 0x12345000
  - 0xFFDFF06F (J) -> 0xFFFFFFFC
- SKID_EN=1, out_ready=0, two beats sent (I 0x00500093, then U 0x123450B7):
  - in_ready drops to 0 after the second beat.
  - Raising out_ready delivers 0x00000005 then 0x12345000, in order, on consecutive cycles.
- Two entries held, flush=1 for one cycle:
  - out_valid=0 and in_ready=1 the next cycle.
  - An input offered during the flush cycle never appears at the output.
- imm_src=110 -> imm_fmt_err=1, imm_ext=0. imm_src=101 with instr=0x0002D073 -> 0x00000005 if IMM_GEN_ZIMM_EN is defined, else imm_fmt_err=1.
- XLEN=64, instr=0x800000B7 (U): imm_ext=0xFFFFFFFF80000000. Then assert rst mid-transfer -> out_valid=0 immediately, without waiting for a clock edge.
